// File: rtl/lm_sm_sequencer_if.sv
// Bus between the memory-access stage and the LM/SM sequencer.
// The stage drives the instruction and base address; the sequencer drives
// the stall, the port-override controls and the transfer bookkeeping.
interface lm_sm_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] base_addr;
    logic              stall;
    logic              active;
    logic [2:0]        reg_index;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              rf_we;
    logic [3:0]        xfer_count;
    logic              done;

    modport master (
        output start, ir, base_addr,
        input  stall, active, reg_index, mem_addr, mem_we, rf_we, xfer_count, done
    );

    modport slave (
        input  start, ir, base_addr,
        output stall, active, reg_index, mem_addr, mem_we, rf_we, xfer_count, done
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: walks the register mask of a load/store-multiple
// instruction one set bit per cycle, lowest register first, producing the
// register index, consecutive memory addresses and the matching write enable.
module lm_sm_sequencer #(
    parameter int          ADDR_W = 16,
    parameter logic [3:0]  OP_LM  = 4'b0110,
    parameter logic [3:0]  OP_SM  = 4'b0111
) (
    input  logic clk,
    input  logic reset,
    lm_sm_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        count_q, count_d;
    logic              is_sm_q, is_sm_d;

    logic [3:0]        op;
    logic              op_ok;
    logic              accept;
    logic [2:0]        low_idx;
    logic [7:0]        mask_rest;

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            addr_q  <= '0;
            count_q <= 4'd0;
            is_sm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            is_sm_q <= is_sm_d;
        end
    end

    // Next-state, datapath update and outputs; accept is only possible outside RUN.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        count_d = count_q;
        is_sm_d = is_sm_q;

        bus.stall      = 1'b0;
        bus.active     = 1'b0;
        bus.reg_index  = 3'd0;
        bus.mem_addr   = '0;
        bus.mem_we     = 1'b0;
        bus.rf_we      = 1'b0;
        bus.done       = 1'b0;
        bus.xfer_count = count_q;

        op     = bus.ir[15:12];
        op_ok  = (op == OP_LM) || (op == OP_SM);
        accept = (state_q != RUN) && bus.start && op_ok;

        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = 3'(i);
            end
        end
        mask_rest = mask_q & (mask_q - 8'd1);

        case (state_q)
            RUN: begin
                bus.stall     = 1'b1;
                bus.active    = 1'b1;
                bus.reg_index = low_idx;
                bus.mem_addr  = addr_q;
                bus.mem_we    = is_sm_q;
                bus.rf_we     = ~is_sm_q;
                mask_d        = mask_rest;
                addr_d        = addr_q + ADDR_W'(1);
                count_d       = count_q + 4'd1;
                if (mask_rest == 8'd0) begin
                    state_d = FINISH;
                end
            end
            IDLE, FINISH: begin
                bus.done = (state_q == FINISH);
                state_d  = IDLE;
                if (accept) begin
                    is_sm_d   = (op == OP_SM);
                    mask_d    = bus.ir[7:0];
                    addr_d    = bus.base_addr;
                    count_d   = 4'd0;
                    bus.stall = |bus.ir[7:0];
                    state_d   = (|bus.ir[7:0]) ? RUN : FINISH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule
